// File: rtl/cpu_top.sv
// rtl/cpu_top.sv - single-cycle 16-bit execution core: 32x16 GPR file, SGPR, ALU, flags
module cpu_top (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic [31:0] ir,
    input  logic        ir_valid,
    input  logic        dbg_wr_en,
    input  logic [4:0]  dbg_wr_addr,
    input  logic [15:0] dbg_wr_data,
    input  logic [4:0]  dbg_rd_addr,
    output logic [15:0] dbg_rd_data,
    output logic [15:0] sgpr,
    output logic        sign,
    output logic        zero,
    output logic        overflow,
    output logic        carry
);

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_ROR     = 5'd5;
    localparam logic [4:0] OP_RAND    = 5'd6;
    localparam logic [4:0] OP_RXOR    = 5'd7;
    localparam logic [4:0] OP_RXNOR   = 5'd8;
    localparam logic [4:0] OP_RNAND   = 5'd9;
    localparam logic [4:0] OP_RNOR    = 5'd10;
    localparam logic [4:0] OP_RNOT    = 5'd11;

    logic [15:0] r_gpr [32];
    logic [15:0] r_sgpr;
    logic        r_sign;
    logic        r_zero;
    logic        r_overflow;
    logic        r_carry;

    logic [4:0]  w_op;
    logic [4:0]  w_rdst;
    logic [4:0]  w_rsrc1;
    logic [4:0]  w_rsrc2;
    logic        w_imm_mode;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [16:0] w_sum;
    logic [15:0] w_diff;
    logic [31:0] w_prod;

    logic [15:0] w_result;
    logic        w_gpr_we;
    logic        w_sgpr_we;
    logic        w_sign;
    logic        w_zero;
    logic        w_overflow;
    logic        w_carry;

    assign w_op       = ir[31:27];
    assign w_rdst     = ir[26:22];
    assign w_rsrc1    = ir[21:17];
    assign w_imm_mode = ir[16];
    assign w_rsrc2    = ir[15:11];

    // Operands come from pre-edge register state so back-to-back instructions never hazard.
    assign w_a    = r_gpr[w_rsrc1];
    assign w_b    = w_imm_mode ? ir[15:0] : r_gpr[w_rsrc2];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = w_a - w_b;
    assign w_prod = {16'd0, w_a} * {16'd0, w_b};

    // ALU result, write enables and next flag values for the current instruction.
    always_comb begin
        w_result   = '0;
        w_gpr_we   = 1'b1;
        w_sgpr_we  = 1'b0;
        w_overflow = 1'b0;
        w_carry    = 1'b0;
        case (w_op)
            OP_MOVSGPR: w_result = r_sgpr;
            OP_MOV:     w_result = w_b;
            OP_ADD: begin
                w_result   = w_sum[15:0];
                w_carry    = w_sum[16];
                w_overflow = (~w_a[15] & ~w_b[15] &  w_sum[15]) |
                             ( w_a[15] &  w_b[15] & ~w_sum[15]);
            end
            OP_SUB: begin
                w_result   = w_diff;
                w_overflow = (~w_a[15] &  w_b[15] &  w_diff[15]) |
                             ( w_a[15] & ~w_b[15] & ~w_diff[15]);
            end
            OP_MUL: begin
                w_result  = w_prod[15:0];
                w_sgpr_we = 1'b1;
            end
            OP_ROR:     w_result = w_a | w_b;
            OP_RAND:    w_result = w_a & w_b;
            OP_RXOR:    w_result = w_a ^ w_b;
            OP_RXNOR:   w_result = ~(w_a ^ w_b);
            OP_RNAND:   w_result = ~(w_a & w_b);
            OP_RNOR:    w_result = ~(w_a | w_b);
            OP_RNOT:    w_result = ~w_a;
            default:    w_gpr_we = 1'b0;
        endcase
        // Multiply flags describe the full 32-bit product, not just the low half.
        if (w_op == OP_MUL) begin
            w_sign = w_prod[31];
            w_zero = (w_prod == 32'd0);
        end else begin
            w_sign = w_result[15];
            w_zero = (w_result == 16'd0);
        end
    end

    // Register file and SGPR; the instruction write is issued last so it wins an address clash.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= '0;
            end
            r_sgpr <= '0;
        end else begin
            if (dbg_wr_en) begin
                r_gpr[dbg_wr_addr] <= dbg_wr_data;
            end
            if (ir_valid && w_gpr_we) begin
                r_gpr[w_rdst] <= w_result;
            end
            if (ir_valid && w_sgpr_we) begin
                r_sgpr <= w_prod[31:16];
            end
        end
    end

    // Condition flags update only on executed instructions that write a register.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
        end else if (ir_valid && w_gpr_we) begin
            r_sign     <= w_sign;
            r_zero     <= w_zero;
            r_overflow <= w_overflow;
            r_carry    <= w_carry;
        end
    end

    assign dbg_rd_data = r_gpr[dbg_rd_addr];
    assign sgpr        = r_sgpr;
    assign sign        = r_sign;
    assign zero        = r_zero;
    assign overflow    = r_overflow;
    assign carry       = r_carry;

endmodule

// File: tb/tb_cpu_top.sv
// tb/tb_cpu_top.sv - randomized and directed self-checking bench for cpu_top
`timescale 1ns/100ps
module tb_cpu_top;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] ir = '0;
    logic        ir_valid = 1'b0;
    logic        dbg_wr_en = 1'b0;
    logic [4:0]  dbg_wr_addr = '0;
    logic [15:0] dbg_wr_data = '0;
    logic [4:0]  dbg_rd_addr = '0;
    logic [15:0] dbg_rd_data;
    logic [15:0] sgpr;
    logic        sign, zero, overflow, carry;

    int tests = 0;
    int fails = 0;

    cpu_top dut (
        .clk(clk), .sys_rst(sys_rst), .ir(ir), .ir_valid(ir_valid),
        .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
        .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data), .sgpr(sgpr),
        .sign(sign), .zero(zero), .overflow(overflow), .carry(carry)
    );

    always #5 clk = ~clk;

    int m_gpr [32];
    int m_sgpr;
    bit m_s, m_z, m_o, m_c;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = 0;
        m_sgpr = 0; m_s = 0; m_z = 0; m_o = 0; m_c = 0;
    endtask

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    always @(posedge sys_rst) model_clear();

    // Reference model: arithmetic on plain integers, applied at each rising edge.
    always @(posedge clk) begin
        if (sys_rst) begin
            model_clear();
        end else begin
            int op, rd, a, b, res, sres;
            longint p;
            bit wr, s, z, o, c;
            int new_sgpr;
            op = int'(ir[31:27]);
            rd = int'(ir[26:22]);
            a  = m_gpr[ir[21:17]];
            b  = ir[16] ? int'(ir[15:0]) : m_gpr[ir[15:11]];
            wr = 1; o = 0; c = 0; res = 0; new_sgpr = m_sgpr; p = 0;
            case (op)
                0: res = m_sgpr;
                1: res = b;
                2: begin
                    res = (a + b) % 65536;
                    c = (a + b) > 65535;
                    sres = to_signed16(a) + to_signed16(b);
                    o = (sres > 32767) || (sres < -32768);
                end
                3: begin
                    res = (a - b + 65536) % 65536;
                    sres = to_signed16(a) - to_signed16(b);
                    o = (sres > 32767) || (sres < -32768);
                end
                4: begin
                    p = longint'(a) * longint'(b);
                    res = int'(p % 65536);
                    new_sgpr = int'(p / 65536);
                end
                5:  res = a | b;
                6:  res = a & b;
                7:  res = a ^ b;
                8:  res = 65535 - (a ^ b);
                9:  res = 65535 - (a & b);
                10: res = 65535 - (a | b);
                11: res = 65535 - a;
                default: wr = 0;
            endcase
            if (op == 4) begin
                s = p >= 64'd2147483648;
                z = (p == 0);
            end else begin
                s = res >= 32768;
                z = (res == 0);
            end
            if (dbg_wr_en) m_gpr[dbg_wr_addr] = int'(dbg_wr_data);
            if (ir_valid && wr) begin
                m_gpr[rd] = res;
                m_sgpr = new_sgpr;
                m_s = s; m_z = z; m_o = o; m_c = c;
            end
        end
    end

    // Every-cycle comparison of all observable state against the model.
    always @(negedge clk) begin
        check("dbg_rd_data", int'(dbg_rd_data), m_gpr[dbg_rd_addr]);
        check("sgpr", int'(sgpr), m_sgpr);
        check("flags", {28'd0, sign, zero, overflow, carry}, {28'd0, m_s, m_z, m_o, m_c});
    end

    function automatic logic [31:0] mk(input int op, input int rd, input int r1,
                                       input bit imm, input int r2_or_imm);
        logic [15:0] low;
        low = imm ? 16'(r2_or_imm) : {5'(r2_or_imm), 11'd0};
        return {5'(op), 5'(rd), 5'(r1), imm, low};
    endfunction

    task automatic issue(input logic [31:0] w);
        @(negedge clk); #1;
        ir = w; ir_valid = 1'b1;
        @(posedge clk); #1;
        ir_valid = 1'b0;
    endtask

    task automatic dbg_write(input int addr, input int data);
        @(negedge clk); #1;
        dbg_wr_en = 1'b1; dbg_wr_addr = 5'(addr); dbg_wr_data = 16'(data);
        @(posedge clk); #1;
        dbg_wr_en = 1'b0;
    endtask

    task automatic rd_check(input string name, input int addr, input int exp);
        dbg_rd_addr = 5'(addr); #1;
        check(name, int'(dbg_rd_data), exp);
    endtask

    task automatic flag_check(input string name, input bit s, input bit z, input bit o, input bit c);
        check(name, {28'd0, sign, zero, overflow, carry}, {28'd0, s, z, o, c});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        flag_check("reset_flags", 0, 0, 0, 0);
        check("reset_sgpr", int'(sgpr), 0);
        @(negedge clk); #1;
        sys_rst = 1'b0;

        dbg_write(1, 16'h0001); dbg_write(2, 16'hFFFF);
        dbg_write(3, 16'h7FFF); dbg_write(4, 16'h8000);

        issue(mk(2, 5, 1, 0, 2));
        rd_check("add_1_ffff", 5, 16'h0000); flag_check("add_1_ffff_f", 0, 1, 0, 1);
        issue(mk(2, 5, 3, 0, 3));
        rd_check("add_7fff_7fff", 5, 16'hFFFE); flag_check("add_7fff_7fff_f", 1, 0, 1, 0);
        issue(mk(2, 5, 3, 0, 4));
        rd_check("add_7fff_8000", 5, 16'hFFFF); flag_check("add_7fff_8000_f", 1, 0, 0, 0);
        issue(mk(3, 5, 3, 0, 4));
        rd_check("sub_7fff_8000", 5, 16'hFFFF); flag_check("sub_7fff_8000_f", 1, 0, 1, 0);
        issue(mk(4, 5, 2, 0, 2));
        rd_check("mul_ffff_sq", 5, 16'h0001); check("mul_ffff_sq_sgpr", int'(sgpr), 16'hFFFE);
        check("mul_ffff_sq_sz", {30'd0, sign, zero}, 2);
        dbg_write(1, 16'hFFFF); dbg_write(2, 16'h0002);
        issue(mk(4, 5, 1, 0, 2));
        rd_check("mul_ffff_2", 5, 16'hFFFE); check("mul_ffff_2_sgpr", int'(sgpr), 16'h0001);
        check("mul_ffff_2_sign", int'(sign), 0);
        issue(mk(0, 6, 0, 0, 0));
        rd_check("movsgpr", 6, 16'h0001);
        issue(mk(2, 7, 3, 1, 16'h0001));
        rd_check("addi", 7, 16'h8000); check("addi_os", {30'd0, overflow, sign}, 3);

        @(negedge clk); #1;
        ir = mk(2, 9, 1, 0, 1); ir_valid = 1'b0;
        @(posedge clk); #1;
        flag_check("no_valid_hold", 1, 0, 1, 0);
        rd_check("no_valid_nowrite", 9, 0);

        @(negedge clk); #1;
        ir = mk(1, 8, 0, 1, 16'h5678); ir_valid = 1'b1;
        dbg_wr_en = 1'b1; dbg_wr_addr = 5'd8; dbg_wr_data = 16'h1234;
        @(posedge clk); #1;
        ir_valid = 1'b0; dbg_wr_en = 1'b0;
        rd_check("clash_ir_wins", 8, 16'h5678);
        @(negedge clk); #1;
        ir = mk(1, 10, 0, 1, 16'h5555); ir_valid = 1'b1;
        dbg_wr_en = 1'b1; dbg_wr_addr = 5'd9; dbg_wr_data = 16'hAAAA;
        @(posedge clk); #1;
        ir_valid = 1'b0; dbg_wr_en = 1'b0;
        rd_check("diff_dbg", 9, 16'hAAAA);
        rd_check("diff_ir", 10, 16'h5555);

        issue(mk(12, 11, 3, 0, 3));
        rd_check("nop_nowrite", 11, 0);
        flag_check("nop_hold", 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) dbg_write(i, int'($urandom_range(0, 65535)));

        for (int n = 0; n < 600; n++) begin
            int op, rd;
            @(negedge clk); #1;
            op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 31))
                                             : int'($urandom_range(0, 11));
            rd = int'($urandom_range(0, 31));
            ir = mk(op, rd, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 65535)));
            if ($urandom_range(0, 3) == 0) ir[15:0] = 16'($urandom_range(0, 3) * 16'h4000);
            ir_valid = ($urandom_range(0, 4) != 0);
            dbg_wr_en = ($urandom_range(0, 3) == 0);
            dbg_wr_addr = ($urandom_range(0, 1) == 0) ? 5'(rd) : 5'($urandom_range(0, 31));
            dbg_wr_data = 16'($urandom_range(0, 65535));
            dbg_rd_addr = ($urandom_range(0, 1) == 0) ? 5'(rd) : 5'($urandom_range(0, 31));
        end
        @(negedge clk); #1;
        ir_valid = 1'b0; dbg_wr_en = 1'b0;

        dbg_write(12, 16'hBEEF);
        issue(mk(2, 13, 12, 1, 16'hFFFF));
        @(posedge clk); #2;
        dbg_rd_addr = 5'd12;
        sys_rst = 1'b1;
        #1;
        flag_check("async_rst_flags", 0, 0, 0, 0);
        check("async_rst_gpr", int'(dbg_rd_data), 0);
        check("async_rst_sgpr", int'(sgpr), 0);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            rd_check("rst_gpr_sweep", i, 0);
        end
        @(negedge clk); #1;
        sys_rst = 1'b0;
        issue(mk(1, 1, 0, 1, 16'h1234));
        rd_check("post_rst_mov", 1, 16'h1234);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_top.md
# cpu_top

Single-cycle 16-bit integer execution core: a 32×16 general-purpose register file, a 16-bit special register (SGPR) holding the upper half of multiply results, an ALU, and a registered condition-flag unit (sign, zero, overflow, carry). It sits at the top of the CPU datapath. It accepts one 32-bit instruction per clock and exposes a debug port for preloading and inspecting registers.

## Interface
- No parameters. Data width is fixed at 16 bits and the register count at 32.
- clk  in  1  system clock, rising-edge active
- sys_rst  in  1  reset, asynchronous, active-high
- ir  in  32  instruction word
- ir_valid  in  1  execute `ir` on this rising edge
- dbg_wr_en  in  1  debug write to GPR
- dbg_wr_addr  in  5  debug write address
- dbg_wr_data  in  16  debug write data
- dbg_rd_addr  in  5  debug read address
- dbg_rd_data  out  16  combinational read of GPR[dbg_rd_addr]
- sgpr  out  16  SGPR contents
- sign  out  1  registered sign flag
- zero  out  1  registered zero flag
- overflow  out  1  registered signed-overflow flag
- carry  out  1  registered unsigned-carry flag

## Operation
- Instruction fields:
  - ir[31:27] oper_type
  - ir[26:22] rdst
  - ir[21:17] rsrc1
  - ir[16] imm_mode
  - ir[15:11] rsrc2
  - ir[15:0] immediate
- Operands:
  - A = GPR[rsrc1]
  - B = imm_mode ? ir[15:0] : GPR[rsrc2]
- Opcodes. The result is written to GPR[rdst] unless noted.
  - 0 movsgpr: SGPR
  - 1 mov: B
  - 2 add: A+B, modulo 2^16
  - 3 sub: A−B, modulo 2^16
  - 4 mul: unsigned 16×16→32 product P. GPR gets P[15:0]; SGPR gets P[31:16].
  - 5 ror: A|B
  - 6 rand: A&B
  - 7 rxor: A^B
  - 8 rxnor: ~(A^B)
  - 9 rnand: ~(A&B)
  - 10 rnor: ~(A|B)
  - 11 rnot: ~A
  - 12–31: no-op. No register is written and the flags hold.
- Flags, with R = the 16-bit result:
  - sign = R[15]; for mul, sign = P[31].
  - zero = (R == 0); for mul, zero = (P == 0).
  - carry = bit 16 of the 17-bit sum A+B for add; 0 for every other opcode.
  - overflow for add = (~A15 & ~B15 & R15) | (A15 & B15 & ~R15).
  - overflow for sub = (~A15 & B15 & R15) | (A15 & ~B15 & ~R15).
  - overflow = 0 for every other opcode.
- Write conflicts:
  - If the instruction and the debug port write the same GPR in the same cycle, the instruction write wins.
  - Writes to different addresses both occur.
- GPR[0] is an ordinary writable register.
- Operands are read from register state as it was before the edge. rdst == rsrc1 is legal and yields the new value after the edge.

## Timing
- Reset (async assert): all GPRs, SGPR, sign, zero, overflow and carry clear to 0 immediately. Reset has priority over all writes.
- Release is synchronous to clk. The first instruction can execute on the first rising edge with sys_rst low.
- Latency is one cycle. On a rising edge with ir_valid=1, GPR[rdst], SGPR (mul only) and all four flags update together.
- dbg_rd_data reflects the new value combinationally after that edge.
- ir_valid=0: no state changes; the flags hold their previous values.
- Back-to-back instructions every cycle are supported, with no hazards; each reads state committed by the previous edge.
- No handshake and no stall. ir and ir_valid are sampled only at the rising edge.

## Test plan
Preload via the debug port: GPR1=0001, GPR2=FFFF, GPR3=7FFF, GPR4=8000.
- add r5,r1,r2 -> GPR5=0000; sign=0, zero=1, overflow=0, carry=1.
- add r5,r3,r3 -> GPR5=FFFE; sign=1, zero=0, overflow=1, carry=0.
- add r5,r3,r4, then sub r5,r3,r4 -> both give GPR5=FFFF.
  - add flags: sign=1, overflow=0, carry=0.
  - sub flags: sign=1, overflow=1, carry=0.
- mul r5,r2,r2 -> GPR5=0001, SGPR=FFFE; sign=1, zero=0.
- Set GPR1=FFFF and GPR2=0002, then mul r5,r1,r2 -> GPR5=FFFE, SGPR=0001, sign=0. Then movsgpr r6 -> GPR6=0001.
- Immediate and reset:
  - Immediate add, GPR3 + 0x0001 -> GPR=8000; overflow=1, sign=1.
  - Assert sys_rst mid-sequence -> all flags and GPRs read 0 without a clock edge.
  - An instruction with ir_valid=0 leaves the flags unchanged.
